// File: rtl/gcm_stream_egress.sv
`default_nettype none
// ============================================================================
// Module   : gcm_stream_egress
// Function : AES-GCM pipeline egress FIFO with credit issue and AXI-stream out
// Revision : 1.0 - initial release
// ============================================================================
module gcm_stream_egress #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_issue,
  output logic              o_issue_ok,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_text,
  input  logic [DATA_W-1:0] i_tuser,
  input  logic [DATA_W-1:0] i_tkeep,
  input  logic              i_tlast,
  output logic              o_tvalid,
  input  logic              i_tready,
  output logic [DATA_W-1:0] o_tdata,
  output logic [DATA_W-1:0] o_tuser,
  output logic [DATA_W-1:0] o_tkeep,
  output logic              o_tlast,
  output logic [31:0]       o_pkt_cnt,
  output logic              o_overflow
);

  localparam int                c_addr_w  = $clog2(DEPTH);
  localparam int                c_ent_w   = 3 * DATA_W + 1;
  localparam logic [c_addr_w:0] c_depth   = (c_addr_w + 1)'(DEPTH);
  localparam logic [c_addr_w:0] c_one     = (c_addr_w + 1)'(1);

  logic [c_addr_w:0]  r_wr_ptr;
  logic [c_addr_w:0]  r_rd_ptr;
  logic [c_addr_w:0]  r_committed;
  logic [31:0]        r_pkt_cnt;
  logic               r_overflow;
  logic [c_ent_w-1:0] r_mem [DEPTH];

  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_issue_ok;
  logic               w_inc;
  logic [c_ent_w-1:0] w_head;
  logic [c_ent_w-1:0] w_out;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                      (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
  assign w_pop      = !w_empty && i_tready;
  // A pop frees its slot in the same cycle, so a full FIFO still accepts a write.
  assign w_push     = i_valid && (!w_full || w_pop);
  assign w_issue_ok = (r_committed < c_depth);
  assign w_inc      = i_issue && w_issue_ok;

  assign w_head = r_mem[r_rd_ptr[c_addr_w-1:0]];
  assign w_out  = w_empty ? '0 : w_head;

  assign o_issue_ok = w_issue_ok;
  assign o_tvalid   = !w_empty;
  assign o_tdata    = w_out[c_ent_w-1 -: DATA_W];
  assign o_tuser    = w_out[2*DATA_W -: DATA_W];
  assign o_tkeep    = w_out[DATA_W -: DATA_W];
  assign o_tlast    = w_out[0];
  assign o_pkt_cnt  = r_pkt_cnt;
  assign o_overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_addr_w-1:0]] <= {i_text, i_tuser, i_tkeep, i_tlast};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_committed <= '0;
      r_pkt_cnt   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_one;
      end
      case ({w_inc, w_pop})
        2'b10:   r_committed <= r_committed + c_one;
        2'b01:   r_committed <= r_committed - c_one;
        default: r_committed <= r_committed;
      endcase
      if (w_pop && w_head[0]) begin
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
      // Either a credit violation or a beat arriving with nowhere to go.
      if ((i_issue && !w_issue_ok) || (i_valid && w_full && !w_pop)) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gcm_stream_egress.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_gcm_stream_egress
// Function : randomized bench for gcm_stream_egress against a queue model
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcm_stream_egress;

  localparam int DEPTH = 16;
  localparam int DW    = 128;
  localparam int LAT   = 15;

  typedef struct packed {
    logic [DW-1:0] text;
    logic [DW-1:0] tuser;
    logic [DW-1:0] tkeep;
    logic          tlast;
  } beat_t;

  typedef struct packed {
    logic  v;
    beat_t b;
  } slot_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_issue = 1'b0;
  logic          o_issue_ok;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_text = '0;
  logic [DW-1:0] i_tuser = '0;
  logic [DW-1:0] i_tkeep = '0;
  logic          i_tlast = 1'b0;
  logic          o_tvalid;
  logic          i_tready = 1'b0;
  logic [DW-1:0] o_tdata;
  logic [DW-1:0] o_tuser;
  logic [DW-1:0] o_tkeep;
  logic          o_tlast;
  logic [31:0]   o_pkt_cnt;
  logic          o_overflow;

  always #5 clk = ~clk;

  gcm_stream_egress #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_issue(i_issue), .o_issue_ok(o_issue_ok),
    .i_valid(i_valid), .i_text(i_text), .i_tuser(i_tuser),
    .i_tkeep(i_tkeep), .i_tlast(i_tlast),
    .o_tvalid(o_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tkeep(o_tkeep), .o_tlast(o_tlast),
    .o_pkt_cnt(o_pkt_cnt), .o_overflow(o_overflow)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: beats held downstream, credits outstanding, sticky error, packets.
  beat_t       mq[$];
  int          m_comm = 0;
  bit          m_ovf = 1'b0;
  logic [31:0] m_pkt = '0;

  slot_t         pipe[$];
  logic [DW-1:0] got_text[$];
  bit            mon_en = 1'b0;
  bit            chk_en = 1'b0;
  bit            want_issue = 1'b0, inj_valid = 1'b0, force_issue = 1'b0, rdy = 1'b0;
  beat_t         next_beat = '0, inj_beat = '0;
  logic [4:0]    occ;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b.text  = {$urandom(), $urandom(), $urandom(), $urandom()};
    b.tuser = {$urandom(), $urandom(), $urandom(), $urandom()};
    b.tkeep = {$urandom(), $urandom(), $urandom(), $urandom()};
    b.tlast = ($urandom_range(0, 3) == 0);
    return b;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_comm = 0;
        m_ovf  = 1'b0;
        m_pkt  = '0;
      end else begin
        bit pop, ok, room;
        pop  = (mq.size() > 0) && i_tready;
        ok   = (m_comm < DEPTH);
        room = (mq.size() < DEPTH) || pop;
        if (i_issue && !ok) m_ovf = 1'b1;
        if (i_issue && ok) m_comm++;
        if (pop) begin
          m_comm--;
          if (mq[0].tlast) m_pkt++;
          void'(mq.pop_front());
        end
        if (i_valid) begin
          if (room) mq.push_back(beat_t'{text: i_text, tuser: i_tuser, tkeep: i_tkeep, tlast: i_tlast});
          else m_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("tvalid", o_tvalid, mq.size() > 0);
      chk("issue_ok", o_issue_ok, m_comm < DEPTH);
      chk("committed", dut.r_committed, m_comm);
      chk("overflow", o_overflow, m_ovf);
      chk("pkt_cnt", o_pkt_cnt, m_pkt);
      if (mq.size() > 0) begin
        chk("tdata", o_tdata, mq[0].text);
        chk("tuser", o_tuser, mq[0].tuser);
        chk("tkeep", o_tkeep, mq[0].tkeep);
        chk("tlast", o_tlast, mq[0].tlast);
      end
    end
    if (mon_en && o_tvalid && i_tready) got_text.push_back(o_tdata);
  end

  task automatic clear_pipe();
    pipe.delete();
    for (int k = 0; k < LAT; k++) pipe.push_back('0);
  endtask

  // One clock of stimulus: the delay line models the fixed-latency pipeline.
  task automatic step(output bit launched);
    slot_t s;
    slot_t n;
    @(posedge clk);
    #1;
    s = pipe.pop_front();
    if (inj_valid) begin
      s.v = 1'b1;
      s.b = inj_beat;
    end
    i_valid  = s.v;
    i_text   = s.b.text;
    i_tuser  = s.b.tuser;
    i_tkeep  = s.b.tkeep;
    i_tlast  = s.b.tlast;
    launched = want_issue && o_issue_ok;
    i_issue  = launched || force_issue;
    n.v      = launched;
    n.b      = next_beat;
    pipe.push_back(n);
    i_tready = rdy;
  endtask

  task automatic idle(input int n);
    bit d;
    for (int k = 0; k < n; k++) step(d);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    i_issue = 1'b0; i_valid = 1'b0; i_tready = 1'b0;
    want_issue = 1'b0; inj_valid = 1'b0; force_issue = 1'b0; rdy = 1'b0;
    clear_pipe();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic fill(input string tag);
    bit l;
    int acc;
    acc = 0;
    rdy = 1'b0;
    for (int k = 0; k < 40; k++) begin
      want_issue = 1'b1;
      next_beat  = rand_beat();
      step(l);
      if (l) acc++;
    end
    want_issue = 1'b0;
    idle(LAT + 2);
    chk({tag, "_accepted"}, acc, 16);
    chk({tag, "_issue_ok_low"}, o_issue_ok, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit l;
    int idx;
    bit ok_order;
    beat_t keep_b;

    clear_pipe();
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("init_issue_ok", o_issue_ok, 1'b1);
    chk("init_tvalid", o_tvalid, 1'b0);

    // Streaming: text carries the beat index, tlast on every 4th beat.
    rdy = 1'b1;
    mon_en = 1'b1;
    got_text.delete();
    idx = 0;
    for (int cyc = 0; cyc < 400 && idx < 64; cyc++) begin
      next_beat.text  = DW'(idx);
      next_beat.tuser = {$urandom(), $urandom(), $urandom(), $urandom()};
      next_beat.tkeep = {$urandom(), $urandom(), $urandom(), $urandom()};
      next_beat.tlast = (idx % 4 == 3);
      want_issue = 1'b1;
      step(l);
      if (l) idx++;
    end
    want_issue = 1'b0;
    idle(LAT + 10);
    mon_en = 1'b0;
    chk("stream_count", got_text.size(), 64);
    ok_order = 1'b1;
    foreach (got_text[i]) if (got_text[i] != DW'(i)) ok_order = 1'b0;
    chk("stream_order", ok_order, 1'b1);
    chk("stream_pkt_cnt", o_pkt_cnt, 16);
    chk("stream_overflow", o_overflow, 1'b0);

    // Randomized traffic honouring credits, random downstream ready.
    for (int k = 0; k < 300; k++) begin
      want_issue = ($urandom_range(0, 3) != 0);
      rdy        = ($urandom_range(0, 2) != 0);
      next_beat  = rand_beat();
      step(l);
    end
    want_issue = 1'b0;
    rdy = 1'b1;
    idle(LAT + DEPTH + 5);
    chk("rand_drained_tvalid", o_tvalid, 1'b0);
    chk("rand_drained_ok", o_issue_ok, 1'b1);

    // Backpressure: credits exhaust at DEPTH, return one cycle after first pop.
    fill("bp");
    got_text.delete();
    mon_en = 1'b1;
    rdy = 1'b1;
    step(l);
    @(negedge clk);
    chk("bp_ok_before_pop", o_issue_ok, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_ok_after_pop", o_issue_ok, 1'b1);
    idle(DEPTH + 4);
    mon_en = 1'b0;
    chk("bp_delivered", got_text.size(), 16);

    // Full FIFO: simultaneous write and pop both accepted.
    fill("full");
    inj_valid = 1'b1;
    inj_beat  = rand_beat();
    rdy = 1'b1;
    step(l);
    inj_valid = 1'b0;
    rdy = 1'b0;
    step(l);
    occ = dut.r_wr_ptr - dut.r_rd_ptr;
    chk("full_simul_occ", occ, 16);
    chk("full_simul_ovf", o_overflow, 1'b0);
    // Write into a full FIFO with no pop is dropped.
    inj_valid = 1'b1;
    inj_beat  = rand_beat();
    step(l);
    inj_valid = 1'b0;
    step(l);
    occ = dut.r_wr_ptr - dut.r_rd_ptr;
    chk("drop_occ", occ, 16);
    chk("drop_ovf", o_overflow, 1'b1);
    do_reset();
    @(negedge clk);
    chk("drop_ovf_cleared", o_overflow, 1'b0);

    // Issue without credit is ignored and flagged.
    fill("cred");
    force_issue = 1'b1;
    step(l);
    force_issue = 1'b0;
    step(l);
    chk("cred_committed", dut.r_committed, 16);
    chk("cred_ovf", o_overflow, 1'b1);
    rdy = 1'b1;
    idle(DEPTH + 4);
    chk("cred_ovf_sticky", o_overflow, 1'b1);
    do_reset();

    // Mid-stream reset with 5 beats buffered.
    rdy = 1'b0;
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      want_issue = 1'b1;
      next_beat  = rand_beat();
      step(l);
      if (l) idx++;
    end
    want_issue = 1'b0;
    idle(LAT + 2);
    chk("rst_buffered", idx, 5);
    chk("rst_pre_tvalid", o_tvalid, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_tvalid", o_tvalid, 1'b0);
    chk("rst_tdata", o_tdata, '0);
    chk("rst_tuser", o_tuser, '0);
    chk("rst_tkeep", o_tkeep, '0);
    chk("rst_tlast", o_tlast, 1'b0);
    chk("rst_pkt_cnt", o_pkt_cnt, '0);
    chk("rst_overflow", o_overflow, 1'b0);
    chk("rst_issue_ok", o_issue_ok, 1'b1);
    chk("rst_committed", dut.r_committed, '0);
    i_issue = 1'b0; i_valid = 1'b0;
    clear_pipe();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_text.delete();
    mon_en = 1'b1;
    rdy = 1'b1;
    keep_b = rand_beat();
    next_beat = keep_b;
    want_issue = 1'b1;
    step(l);
    want_issue = 1'b0;
    idle(LAT + 4);
    mon_en = 1'b0;
    chk("post_rst_count", got_text.size(), 1);
    if (got_text.size() > 0) chk("post_rst_beat", got_text[0], keep_b.text);

    // Packet counter wrap.
    step(l);
    force dut.r_pkt_cnt = 32'hFFFF_FFFF;
    m_pkt = 32'hFFFF_FFFF;
    #1;
    release dut.r_pkt_cnt;
    @(negedge clk);
    chk("wrap_preload", o_pkt_cnt, 32'hFFFF_FFFF);
    next_beat = rand_beat();
    next_beat.tlast = 1'b1;
    want_issue = 1'b1;
    step(l);
    want_issue = 1'b0;
    idle(LAT + 4);
    chk("wrap_pkt_cnt", o_pkt_cnt, 32'h0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
